// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, ALU input select and
// load-use hazard detection for the RV32I core.

package id_ex_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;
endpackage

// One forwarding mux per source operand; MEM is younger than WB so it wins.
module id_ex_fwd_mux #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] rs_data,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_rd_we,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_rd_we,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] value
);
    always_comb begin
        value = rs_data;
        if (FWD_EN && rs != '0) begin
            if (mem_rd_we && mem_rd == rs)
                value = mem_result;
            else if (wb_rd_we && wb_rd == rs)
                value = wb_result;
        end
    end
endmodule

module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [3:0]      id_alu_op,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            id_sel_a,
    input  logic            id_sel_b,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_rd_we,
    input  logic            id_is_load,
    input  logic            stall,
    input  logic            flush,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_rd_we,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_rd_we,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_in1,
    output logic [XLEN-1:0] ex_in2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_rd_we,
    output logic            ex_is_load,
    output logic            load_use_hazard
);
    import id_ex_pkg::*;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            sel_a;
        logic            sel_b;
        logic [RA_W-1:0] rd;
        logic            rd_we;
        logic            is_load;
    } ex_fields_t;

    ex_fields_t id_f, ex_q;
    logic       ex_valid_q;

    always_comb begin
        id_f          = '0;
        id_f.alu_op   = id_alu_op;
        id_f.rs1      = id_rs1;
        id_f.rs2      = id_rs2;
        id_f.rs1_data = id_rs1_data;
        id_f.rs2_data = id_rs2_data;
        id_f.imm      = id_imm;
        id_f.pc       = id_pc;
        id_f.sel_a    = id_sel_a;
        id_f.sel_b    = id_sel_b;
        id_f.rd       = id_rd;
        id_f.rd_we    = id_rd_we;
        id_f.is_load  = id_is_load;
    end

    // Both sources compared even if the instruction ignores one: cheaper than decoding use.
    assign load_use_hazard = ex_valid_q & ex_q.is_load & (ex_q.rd != '0) & id_valid &
                             ((id_rs1 == ex_q.rd) | (id_rs2 == ex_q.rd));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            ex_q.alu_op <= ALU_ADD;
            ex_valid_q  <= 1'b0;
        end else if (flush) begin
            ex_valid_q  <= 1'b0;
        end else if (stall) begin
            ex_valid_q  <= ex_valid_q;
        end else if (load_use_hazard) begin
            ex_valid_q  <= 1'b0;
        end else begin
            ex_q        <= id_f;
            ex_valid_q  <= id_valid;
        end
    end

    // Index 0 = rs1, index 1 = rs2.
    logic [1:0][RA_W-1:0] src_rs;
    logic [1:0][XLEN-1:0] src_data;
    logic [1:0][XLEN-1:0] src_fwd;

    assign src_rs   = {ex_q.rs2, ex_q.rs1};
    assign src_data = {ex_q.rs2_data, ex_q.rs1_data};

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        id_ex_fwd_mux #(
            .XLEN   (XLEN),
            .RA_W   (RA_W),
            .FWD_EN (FWD_EN)
        ) u_fwd (
            .rs         (src_rs[i]),
            .rs_data    (src_data[i]),
            .mem_rd     (mem_rd),
            .mem_rd_we  (mem_rd_we),
            .mem_result (mem_result),
            .wb_rd      (wb_rd),
            .wb_rd_we   (wb_rd_we),
            .wb_result  (wb_result),
            .value      (src_fwd[i])
        );
    end

    assign ex_valid      = ex_valid_q;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_in1        = ex_q.sel_a ? ex_q.pc  : src_fwd[0];
    assign ex_in2        = ex_q.sel_b ? ex_q.imm : src_fwd[1];
    assign ex_store_data = src_fwd[1];
    assign ex_rd         = ex_q.rd;
    assign ex_rd_we      = ex_valid_q & ex_q.rd_we;
    assign ex_is_load    = ex_valid_q & ex_q.is_load;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding priority, x0, load-use,
// stall/flush and operand select, all with hand-computed expectations.
module tb_id_ex_operand_stage;
    import id_ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        id_sel_a, id_sel_b, id_rd_we, id_is_load;
    logic        stall, flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_rd_we, wb_rd_we;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_rd_we, ex_is_load, load_use_hazard;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_in1, ex_in2, ex_store_data;
    logic [4:0]  ex_rd;

    int errors = 0;
    int checks = 0;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc),
        .id_sel_a(id_sel_a), .id_sel_b(id_sel_b),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .stall(stall), .flush(flush),
        .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_rd_we(wb_rd_we), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs settle 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_idle();
        id_valid = 0; id_alu_op = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
        id_sel_a = 0; id_sel_b = 0; id_rd_we = 0; id_is_load = 0;
    endtask

    task automatic fwd_idle();
        mem_rd = 0; mem_rd_we = 0; mem_result = 0;
        wb_rd = 0; wb_rd_we = 0; wb_result = 0;
    endtask

    task automatic id_set(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [4:0] rd, input logic we, input logic ld);
        id_valid = 1; id_alu_op = op; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_rd = rd; id_rd_we = we; id_is_load = ld;
        id_sel_a = 0; id_sel_b = 0; id_imm = 0; id_pc = 0;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        id_idle(); fwd_idle();
        step(); step();
        rst = 0;

        // 1: reset mid-stream, while a stall is active
        id_set(4'd5, 5'd1, 5'd2, 32'h1, 32'h2, 5'd3, 1'b1, 1'b0);
        step();
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        stall = 1;
        #2 rst = 1;
        #1;
        chk("rst_async_valid", 32'(ex_valid), 32'd0);
        chk("rst_async_rd_we", 32'(ex_rd_we), 32'd0);
        step();
        id_idle(); stall = 0; rst = 0;
        step();
        chk("rst_rel_valid", 32'(ex_valid), 32'd0);
        chk("rst_rel_rd_we", 32'(ex_rd_we), 32'd0);
        chk("rst_rel_alu_op", 32'(ex_alu_op), 32'(ALU_ADD));
        chk("rst_rel_rd", 32'(ex_rd), 32'd0);

        // 2: MEM wins over WB; WB when MEM drops; regfile when both drop
        id_set(4'd0, 5'd5, 5'd6, 32'h99, 32'h66, 5'd10, 1'b1, 1'b0);
        step();
        id_idle();
        mem_rd = 5; mem_rd_we = 1; mem_result = 32'h11;
        wb_rd = 5; wb_rd_we = 1; wb_result = 32'h22;
        #1 chk("fwd_mem_pri", ex_in1, 32'h11);
        chk("fwd_rs2_untouched", ex_in2, 32'h66);
        mem_rd_we = 0;
        #1 chk("fwd_wb", ex_in1, 32'h22);
        wb_rd_we = 0;
        #1 chk("fwd_none", ex_in1, 32'h99);
        fwd_idle();

        // 3: x0 is never forwarded
        id_set(4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        step();
        id_idle();
        mem_rd = 0; mem_rd_we = 1; mem_result = 32'hDEAD;
        wb_rd = 0; wb_rd_we = 1; wb_result = 32'hBEEF;
        #1 chk("x0_in2", ex_in2, 32'h0);
        chk("x0_store", ex_store_data, 32'h0);
        chk("x0_in1", ex_in1, 32'h0);
        fwd_idle();

        // 4: load-use hazard on rs2 -> one bubble, then capture
        id_set(4'd0, 5'd1, 5'd2, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1);
        step();
        chk("ld_is_load", 32'(ex_is_load), 32'd1);
        id_set(4'd1, 5'd3, 5'd7, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);
        #1 chk("lu_hazard", 32'(load_use_hazard), 32'd1);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_rd_we", 32'(ex_rd_we), 32'd0);
        chk("lu_bubble_is_load", 32'(ex_is_load), 32'd0);
        chk("lu_hazard_clr", 32'(load_use_hazard), 32'd0);
        step();
        chk("lu_cap_valid", 32'(ex_valid), 32'd1);
        chk("lu_cap_rd", 32'(ex_rd), 32'd8);
        chk("lu_cap_op", 32'(ex_alu_op), 32'd1);
        // load to x0 never raises the hazard
        id_set(4'd0, 5'd1, 5'd2, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
        step();
        id_set(4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);
        #1 chk("lu_x0_none", 32'(load_use_hazard), 32'd0);
        step();

        // 5: stall holds EX for 3 cycles while ID changes; flush beats stall
        id_set(4'd9, 5'd4, 5'd0, 32'h1234, 32'h0, 5'd12, 1'b1, 1'b0);
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_set(4'(i + 2), 5'(i + 20), 5'(i + 21), 32'($urandom), 32'($urandom),
                   5'(i + 1), 1'b0, 1'b0);
            step();
            chk("stall_op", 32'(ex_alu_op), 32'd9);
            chk("stall_rd", 32'(ex_rd), 32'd12);
            chk("stall_in1", ex_in1, 32'h1234);
            chk("stall_valid", 32'(ex_valid), 32'd1);
        end
        flush = 1;
        step();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_rd_we", 32'(ex_rd_we), 32'd0);
        stall = 0; flush = 0;

        // 6: pc/imm select; store data still forwarded
        id_set(4'd0, 5'd1, 5'd9, 32'h7, 32'h3, 5'd2, 1'b0, 1'b0);
        id_sel_a = 1; id_pc = 32'h100; id_sel_b = 1; id_imm = 32'hFFFF_FFFC;
        step();
        id_idle();
        mem_rd = 9; mem_rd_we = 1; mem_result = 32'h55;
        #1 chk("sel_in1_pc", ex_in1, 32'h100);
        chk("sel_in2_imm", ex_in2, 32'hFFFF_FFFC);
        chk("sel_store_fwd", ex_store_data, 32'h55);
        chk("sel_rd_we", 32'(ex_rd_we), 32'd0);
        fwd_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000ns");
        $fatal(1);
    end
endmodule
